// File: rtl/odyssey_pkg.sv
// Shared types for the Odyssey analog conditioner: axis/accumulator types, FSM states
// and the output slew helper.
package odyssey_pkg;

  localparam int NUM_AXES = 8;

  typedef logic [2:0]         axis_idx_t;
  typedef logic signed [7:0]  axis_t;
  typedef logic signed [15:0] acc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } cond_state_t;

  // Moves cur toward tgt by at most lim; the difference needs 9 bits to avoid wrap.
  function automatic axis_t slew_step(axis_t cur, axis_t tgt, logic signed [8:0] lim);
    logic signed [8:0] delta;
    delta = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
    if (delta > lim) begin
      delta = lim;
    end else if (delta < -lim) begin
      delta = -lim;
    end
    return axis_t'(cur + delta[7:0]);
  endfunction

endpackage

// File: rtl/odyssey_axis_math.sv
// Combinational per-axis step: deadzone on the raw stick byte, then one IIR step of the
// 8.8 accumulator toward the deadzoned target.
module odyssey_axis_math
  import odyssey_pkg::*;
#(
  parameter int DEADZONE   = 4,
  parameter int FILT_SHIFT = 2
) (
  input  axis_t x,
  input  acc_t  acc,
  output acc_t  acc_next
);

  localparam logic signed [8:0] DZ9 = 9'(DEADZONE);

  logic signed [8:0]  a;
  logic signed [8:0]  d;
  logic signed [16:0] target;
  logic signed [16:0] diff;
  logic signed [16:0] step;

  always_comb begin
    a = {x[7], x};
    d = '0;
    if (a > DZ9) begin
      d = a - DZ9;
    end else if (a < -DZ9) begin
      d = a + DZ9;
    end
    target = {d, 8'h00};
    diff   = target - {acc[15], acc};
    step   = diff >>> FILT_SHIFT;
    // A shift that rounds a small error to zero would park the filter short of the target.
    if (step == '0 && diff != '0) begin
      step = diff[16] ? -17'sd1 : 17'sd1;
    end
    acc_next = acc + $signed(step[15:0]);
  end

endmodule

// File: rtl/odyssey_analog_conditioner.sv
// Per-frame conditioning of four HPS analog sticks into eight signed pot positions.
// Define ODYSSEY_ANALOG_SLEW_EN to limit each output's change per commit to MAX_STEP.
module odyssey_analog_conditioner
  import odyssey_pkg::*;
#(
  parameter int DEADZONE   = 4,
  parameter int FILT_SHIFT = 2,
  parameter int MAX_STEP   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_sync,
  input  logic [15:0] analog_l0,
  input  logic [15:0] analog_r0,
  input  logic [15:0] analog_l1,
  input  logic [15:0] analog_r1,
  output axis_t       analog1x_p1,
  output axis_t       analog1y_p1,
  output axis_t       analog2x_p1,
  output axis_t       analog2y_p1,
  output axis_t       analog1x_p2,
  output axis_t       analog1y_p2,
  output axis_t       analog2x_p2,
  output axis_t       analog2y_p2,
  output logic        out_valid,
  output cond_state_t fsm_state
);

`ifdef ODYSSEY_ANALOG_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif
  localparam logic signed [8:0] STEP_LIM = 9'(MAX_STEP);

  cond_state_t state, state_n;
  axis_idx_t   idx, idx_n;
  logic        sync_d;
  logic        start;
  logic [63:0] snap;
  acc_t        acc [NUM_AXES];
  axis_t       out_r [NUM_AXES];
  axis_t       commit_val [NUM_AXES];
  axis_t       cur_x;
  acc_t        acc_next;
  logic        s1_valid;
  axis_idx_t   s1_idx;
  acc_t        s1_acc;

  // Handshake: frame_sync is a level; only a rising edge seen while IDLE starts an
  // update, anything else is dropped. out_valid is a single-cycle strobe with no ready.
  assign start = frame_sync & ~sync_d & (state == IDLE);
  assign cur_x = snap[{idx, 3'b000} +: 8];

  odyssey_axis_math #(
    .DEADZONE  (DEADZONE),
    .FILT_SHIFT(FILT_SHIFT)
  ) u_math (
    .x       (cur_x),
    .acc     (acc[idx]),
    .acc_next(acc_next)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CALC;
          idx_n   = '0;
        end
      end
      CALC: begin
        idx_n = idx + 1'b1;
        if (idx == axis_idx_t'(NUM_AXES - 1)) begin
          state_n = DRAIN;
        end
      end
      DRAIN:   state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      commit_val[i] = SLEW_ON ? slew_step(out_r[i], axis_t'(acc[i][15:8]), STEP_LIM)
                              : axis_t'(acc[i][15:8]);
    end
  end

  // Stage 1 registers the shared math result; stage 2 writes it back, so the last
  // axis lands during DRAIN and COMMIT sees all eight accumulators settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d    <= 1'b0;
      snap      <= '0;
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_acc    <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        acc[i]   <= '0;
        out_r[i] <= '0;
      end
    end else begin
      sync_d    <= frame_sync;
      out_valid <= (state == COMMIT);
      s1_valid  <= (state == CALC);
      s1_idx    <= idx;
      s1_acc    <= acc_next;
      if (start) begin
        snap <= {analog_r1, analog_l1, analog_r0, analog_l0};
      end
      if (s1_valid) begin
        acc[s1_idx] <= s1_acc;
      end
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_AXES; i++) begin
          out_r[i] <= commit_val[i];
        end
      end
    end
  end

  assign analog1x_p1 = out_r[0];
  assign analog1y_p1 = out_r[1];
  assign analog2x_p1 = out_r[2];
  assign analog2y_p1 = out_r[3];
  assign analog1x_p2 = out_r[4];
  assign analog1y_p2 = out_r[5];
  assign analog2x_p2 = out_r[6];
  assign analog2y_p2 = out_r[7];
  assign fsm_state   = state;

endmodule

// File: tb/tb_odyssey_analog_conditioner.sv
// Bench for odyssey_analog_conditioner: three parameterisations driven in lockstep and
// compared against an integer model of deadzone, filter and (optionally) slew.
module tb_odyssey_analog_conditioner;
  import odyssey_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              frame_sync;
  logic [15:0]       analog_l0, analog_r0, analog_l1, analog_r1;
  logic [2:0][63:0]  o;
  logic [2:0]        ov;
  cond_state_t       st [3];

  int n_checks = 0;
  int n_fail   = 0;
  int first_k [3];
  int pulses  [3];
  int m_acc [3][8];
  int m_out [3][8];
  int dz_p [3] = '{4, 0, 0};
  int fs_p [3] = '{0, 2, 0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    odyssey_analog_conditioner #(
      .DEADZONE  ((g == 0) ? 4 : 0),
      .FILT_SHIFT((g == 1) ? 2 : 0),
      .MAX_STEP  (8)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_sync (frame_sync),
      .analog_l0  (analog_l0),
      .analog_r0  (analog_r0),
      .analog_l1  (analog_l1),
      .analog_r1  (analog_r1),
      .analog1x_p1(o[g][7:0]),
      .analog1y_p1(o[g][15:8]),
      .analog2x_p1(o[g][23:16]),
      .analog2y_p1(o[g][31:24]),
      .analog1x_p2(o[g][39:32]),
      .analog1y_p2(o[g][47:40]),
      .analog2x_p2(o[g][55:48]),
      .analog2y_p2(o[g][63:56]),
      .out_valid  (ov[g]),
      .fsm_state  (st[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] dut_byte(int n, int i);
    return o[n][i*8 +: 8];
  endfunction

  function automatic int dz_fn(int a, int z);
    if (a > z) return a - z;
    if (a < -z) return a + z;
    return 0;
  endfunction

  // Reference: target is the deadzoned value in 1/256 units, the accumulator closes
  // 1/2^shift of the gap each frame (never less than one unit), output is its integer part.
  task automatic model_frame(input logic [63:0] v);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        int a, t, diff, step, hi;
        a    = int'($signed(v[i*8 +: 8]));
        t    = dz_fn(a, dz_p[n]) * 256;
        diff = t - m_acc[n][i];
        step = diff >>> fs_p[n];
        if (step == 0 && diff != 0) step = (diff > 0) ? 1 : -1;
        m_acc[n][i] = m_acc[n][i] + step;
        hi = m_acc[n][i] >>> 8;
`ifdef ODYSSEY_ANALOG_SLEW_EN
        begin
          int delta;
          delta = hi - m_out[n][i];
          if (delta > 8) delta = 8;
          if (delta < -8) delta = -8;
          m_out[n][i] = m_out[n][i] + delta;
        end
`else
        m_out[n][i] = hi;
`endif
      end
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        m_acc[n][i] = 0;
        m_out[n][i] = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    frame_sync = 1'b0;
    {analog_r1, analog_l1, analog_r0, analog_l0} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  // Runs one update and watches 16 edges; edge 1 is the start edge.
  task automatic run_frame(input logic [63:0] v, input bit hold, input bit overlap);
    for (int n = 0; n < 3; n++) begin
      first_k[n] = 0;
      pulses[n]  = 0;
    end
    @(negedge clk);
    {analog_r1, analog_l1, analog_r0, analog_l0} = v;
    frame_sync = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) begin
        if (ov[n] === 1'b1) begin
          pulses[n]++;
          if (first_k[n] == 0) first_k[n] = k;
        end
      end
      @(negedge clk);
      if (k == 1 && !hold) frame_sync = 1'b0;
      if (overlap && k == 3) begin
        {analog_r1, analog_l1, analog_r0, analog_l0} = {$urandom, $urandom};
        frame_sync = 1'b1;
      end
      if (overlap && k == 4) frame_sync = 1'b0;
    end
    frame_sync = 1'b0;
    model_frame(v);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    frame_sync = 1'b0;
    {analog_r1, analog_l1, analog_r0, analog_l0} = 64'h7f7f_8080_4040_c0c0;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (o[n] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_outputs u%0d: got %h expected 0", n, o[n]);
      end
      n_checks++;
      if (ov[n] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid u%0d: got %b expected 0", n, ov[n]);
      end
      n_checks++;
      if (st[n] !== IDLE) begin
        n_fail++;
        $display("FAIL reset_state u%0d: got %0d expected %0d", n, st[n], IDLE);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (ov !== 3'b000) seen++;
      end
      n_checks++;
      if (seen != 0) begin
        n_fail++;
        $display("FAIL idle_no_valid: got %0d pulses expected 0", seen);
      end
    end
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (o[n] !== 64'd0) begin
        n_fail++;
        $display("FAIL idle_outputs u%0d: got %h expected 0", n, o[n]);
      end
    end
  endtask

  task automatic test_deadzone_latency();
    logic [7:0] xs [3] = '{8'd64, 8'hfd, 8'h80};
    int         ex [3] = '{60, 0, -124};
    do_reset();
    for (int t = 0; t < 3; t++) begin
      logic [63:0] v;
      v = '0;
      v[7:0] = xs[t];
      run_frame(v, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (first_k[n] != 11 || pulses[n] != 1) begin
          n_fail++;
          $display("FAIL latency u%0d: got edge %0d pulses %0d expected edge 11 pulses 1",
                   n, first_k[n], pulses[n]);
        end
        for (int i = 0; i < 8; i++) begin
          logic [7:0] exp_b;
          exp_b = 8'(m_out[n][i]);
          n_checks++;
          if (dut_byte(n, i) !== exp_b) begin
            n_fail++;
            $display("FAIL deadzone u%0d axis%0d: got %0d expected %0d",
                     n, i, $signed(dut_byte(n, i)), $signed(exp_b));
          end
        end
      end
`ifndef ODYSSEY_ANALOG_SLEW_EN
      n_checks++;
      if (dut_byte(0, 0) !== 8'(ex[t])) begin
        n_fail++;
        $display("FAIL deadzone_const x=%0d: got %0d expected %0d",
                 $signed(xs[t]), $signed(dut_byte(0, 0)), ex[t]);
      end
`endif
    end
  endtask

  task automatic test_filter();
    logic [63:0] v;
    do_reset();
    v = '0;
    v[15:8] = 8'd100;
    for (int f = 1; f <= 40; f++) begin
      run_frame(v, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] exp_b;
          exp_b = 8'(m_out[n][i]);
          n_checks++;
          if (dut_byte(n, i) !== exp_b) begin
            n_fail++;
            $display("FAIL filter f%0d u%0d axis%0d: got %0d expected %0d",
                     f, n, i, $signed(dut_byte(n, i)), $signed(exp_b));
          end
        end
      end
`ifndef ODYSSEY_ANALOG_SLEW_EN
      if (f <= 2) begin
        n_checks++;
        if (dut_byte(1, 1) !== ((f == 1) ? 8'd25 : 8'd43)) begin
          n_fail++;
          $display("FAIL filter_const frame%0d: got %0d expected %0d",
                   f, dut_byte(1, 1), (f == 1) ? 25 : 43);
        end
      end
`endif
    end
    n_checks++;
    if (dut_byte(1, 1) !== 8'd100) begin
      n_fail++;
      $display("FAIL filter_converge: got %0d expected 100", $signed(dut_byte(1, 1)));
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      run_frame({$urandom, $urandom}, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (first_k[n] != 11 || pulses[n] != 1) begin
          n_fail++;
          $display("FAIL random_valid u%0d: got edge %0d pulses %0d expected edge 11 pulses 1",
                   n, first_k[n], pulses[n]);
        end
        for (int i = 0; i < 8; i++) begin
          logic [7:0] exp_b;
          exp_b = 8'(m_out[n][i]);
          n_checks++;
          if (dut_byte(n, i) !== exp_b) begin
            n_fail++;
            $display("FAIL random f%0d u%0d axis%0d: got %0d expected %0d",
                     f, n, i, $signed(dut_byte(n, i)), $signed(exp_b));
          end
        end
      end
    end
  endtask

  // hold = 1 keeps frame_sync high; overlap = 1 re-pulses it with new inputs mid-CALC.
  task automatic test_back_to_back(input bit hold, input bit overlap);
    run_frame({$urandom, $urandom}, hold, overlap);
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (first_k[n] != 11 || pulses[n] != 1) begin
        n_fail++;
        $display("FAIL single_update hold=%0d overlap=%0d u%0d: got edge %0d pulses %0d expected edge 11 pulses 1",
                 hold, overlap, n, first_k[n], pulses[n]);
      end
      for (int i = 0; i < 8; i++) begin
        logic [7:0] exp_b;
        exp_b = 8'(m_out[n][i]);
        n_checks++;
        if (dut_byte(n, i) !== exp_b) begin
          n_fail++;
          $display("FAIL snapshot u%0d axis%0d: got %0d expected %0d",
                   n, i, $signed(dut_byte(n, i)), $signed(exp_b));
        end
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    run_frame(64'h6464_9c9c_3232_cece, 1'b0, 1'b0);
    @(negedge clk);
    {analog_r1, analog_l1, analog_r0, analog_l0} = {$urandom, $urandom};
    frame_sync = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_n    = 1'b0;
    frame_sync = 1'b0;
    #1;
    model_clear();
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (o[n] !== 64'd0 || ov[n] !== 1'b0 || st[n] !== IDLE) begin
        n_fail++;
        $display("FAIL midcalc_reset u%0d: got out %h valid %b state %0d expected 0 0 %0d",
                 n, o[n], ov[n], st[n], IDLE);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (ov !== 3'b000) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midcalc_no_valid: got %0d pulses expected 0", seen);
    end
    run_frame({$urandom, $urandom}, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] exp_b;
        exp_b = 8'(m_out[n][i]);
        n_checks++;
        if (dut_byte(n, i) !== exp_b) begin
          n_fail++;
          $display("FAIL after_reset u%0d axis%0d: got %0d expected %0d",
                   n, i, $signed(dut_byte(n, i)), $signed(exp_b));
        end
      end
    end
  endtask

  task automatic test_slew();
    logic [63:0] v;
    int frames;
    do_reset();
    v = '0;
    v[55:48] = 8'd100;
`ifdef ODYSSEY_ANALOG_SLEW_EN
    frames = 14;
`else
    frames = 1;
`endif
    for (int f = 1; f <= frames; f++) begin
      int want;
      want = (8 * f > 100) ? 100 : 8 * f;
`ifndef ODYSSEY_ANALOG_SLEW_EN
      want = 100;
`endif
      run_frame(v, 1'b0, 1'b0);
      n_checks++;
      if (dut_byte(2, 6) !== 8'(want)) begin
        n_fail++;
        $display("FAIL slew frame%0d: got %0d expected %0d", f, $signed(dut_byte(2, 6)), want);
      end
      for (int n = 0; n < 3; n++) begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] exp_b;
          exp_b = 8'(m_out[n][i]);
          n_checks++;
          if (dut_byte(n, i) !== exp_b) begin
            n_fail++;
            $display("FAIL slew_model f%0d u%0d axis%0d: got %0d expected %0d",
                     f, n, i, $signed(dut_byte(n, i)), $signed(exp_b));
          end
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_deadzone_latency();
    test_filter();
    test_random();
    test_back_to_back(1'b0, 1'b1);
    test_back_to_back(1'b1, 1'b0);
    test_reset_mid_calc();
    test_slew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
